// File: rtl/masking_pkg.sv
// Shared types and helpers for the masked-share datapath.
// Share k of a bus lives at bit offset share_lo(k, width).
package masking_pkg;

  typedef struct packed {
    logic valid;
    logic ready;
  } handshake_t;

  function automatic int nshares(input int order);
    return order + 1;
  endfunction

  function automatic int share_lo(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/share_stage.sv
// One elastic register stage that XORs ORDER random words into a share bus.
// The last share absorbs the XOR of all random words, so the recombined value is unchanged.
module share_stage
  import masking_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ORDER   = 1,
  parameter int NSHARES = nshares(ORDER)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NSHARES*WIDTH-1:0]   in_shares,
  input  logic [ORDER*WIDTH-1:0]     rand_words,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NSHARES*WIDTH-1:0]   out_shares
);

  logic                     valid_q;
  logic [NSHARES*WIDTH-1:0] shares_q;
  logic [NSHARES*WIDTH-1:0] mixed;
  logic [WIDTH-1:0]         rand_sum;

  assign in_ready   = !valid_q || out_ready;
  assign out_valid  = valid_q;
  assign out_shares = shares_q;

  always_comb begin
    mixed    = in_shares;
    rand_sum = '0;
    for (int k = 0; k < ORDER; k++) begin
      mixed[share_lo(k, WIDTH) +: WIDTH] =
        in_shares[share_lo(k, WIDTH) +: WIDTH] ^ rand_words[share_lo(k, WIDTH) +: WIDTH];
      rand_sum = rand_sum ^ rand_words[share_lo(k, WIDTH) +: WIDTH];
    end
    mixed[share_lo(ORDER, WIDTH) +: WIDTH] = in_shares[share_lo(ORDER, WIDTH) +: WIDTH] ^ rand_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      shares_q <= '0;
    end else begin
      // Shares only change on a load, so a stalled output stays bit-stable.
      if (in_valid && in_ready) shares_q <= mixed;
      if (in_ready) valid_q <= in_valid;
    end
  end

endmodule

// File: rtl/masked_share_encoder.sv
// Splits a plain value into ORDER+1 register-isolated Boolean shares.
// SHARE_ENC_REFRESH_EN adds a second stage that re-masks the shares with p_rand_1.
module masked_share_encoder
  import masking_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ORDER = 1,
  localparam int NSHARES = nshares(ORDER)
) (
  input  logic                       clock_0,
  input  logic                       reset_0,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [ORDER*WIDTH-1:0]     p_rand_0,
  input  logic [ORDER*WIDTH-1:0]     p_rand_1,
  input  logic                       rand_valid,
  output logic                       rand_ack,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NSHARES*WIDTH-1:0]   out_shares
);

  handshake_t               in_hs;
  logic                     accept;
  logic                     s1_in_ready;
  logic                     s1_valid;
  logic                     s1_out_ready;
  logic [NSHARES*WIDTH-1:0] s1_shares;
  logic [NSHARES*WIDTH-1:0] seed_shares;

  // Low shares start at zero and take the random words directly.
  assign seed_shares = {in_data, {(ORDER*WIDTH){1'b0}}};

  assign in_ready = !reset_0 && rand_valid && s1_in_ready;
  assign in_hs    = '{valid: in_valid, ready: in_ready};
  assign accept   = in_hs.valid && in_hs.ready;

  share_stage #(.WIDTH(WIDTH), .ORDER(ORDER)) u_stage1 (
    .clk        (clock_0),
    .rst        (reset_0),
    .in_valid   (accept),
    .in_ready   (s1_in_ready),
    .in_shares  (seed_shares),
    .rand_words (p_rand_0),
    .out_valid  (s1_valid),
    .out_ready  (s1_out_ready),
    .out_shares (s1_shares)
  );

`ifdef SHARE_ENC_REFRESH_EN
  logic s2_in_ready;
  logic s2_load;

  // Stage 2 needs fresh p_rand_1, so it only advances while rand_valid is high.
  assign s1_out_ready = !reset_0 && rand_valid && s2_in_ready;
  assign s2_load      = s1_valid && s1_out_ready;
  assign rand_ack     = accept || s2_load;

  share_stage #(.WIDTH(WIDTH), .ORDER(ORDER)) u_stage2 (
    .clk        (clock_0),
    .rst        (reset_0),
    .in_valid   (s2_load),
    .in_ready   (s2_in_ready),
    .in_shares  (s1_shares),
    .rand_words (p_rand_1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares)
  );
`else
  logic unused_rand_1;

  assign unused_rand_1 = ^p_rand_1;
  assign s1_out_ready  = out_ready;
  assign rand_ack      = accept;
  assign out_valid     = s1_valid;
  assign out_shares    = s1_shares;
`endif

endmodule

// File: tb/tb_masked_share_encoder.sv
// Self-checking bench for masked_share_encoder (WIDTH=8, ORDER=1).
// The reference model is a queue of expected share buses with a one-entry pipeline capacity.
module tb_masked_share_encoder;

  logic        clock_0 = 1'b0;
  logic        reset_0 = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic [7:0]  p_rand_0 = '0;
  logic [7:0]  p_rand_1 = '0;
  logic        rand_valid = 1'b0;
  logic        rand_ack;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_shares;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  masked_share_encoder #(.WIDTH(8), .ORDER(1)) dut (
    .clock_0    (clock_0),
    .reset_0    (reset_0),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .p_rand_0   (p_rand_0),
    .p_rand_1   (p_rand_1),
    .rand_valid (rand_valid),
    .rand_ack   (rand_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares)
  );

  always #5 clock_0 = ~clock_0;

  task automatic drive(input logic iv, input logic [7:0] d, input logic [7:0] r0,
                       input logic [7:0] r1, input logic rv, input logic ordy);
    @(negedge clock_0);
    in_valid = iv; in_data = d; p_rand_0 = r0; p_rand_1 = r1;
    rand_valid = rv; out_ready = ordy;
    #1;
  endtask

  // Spec-level acceptance: fresh randomness and a free (or draining) slot.
  function automatic logic exp_ready();
    return !reset_0 && rand_valid && (exp_q.size() == 0 || out_ready);
  endfunction

  task automatic model_edge(output logic acc);
    acc = in_valid && exp_ready();
    @(posedge clock_0);
    if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (acc) exp_q.push_back({in_data ^ p_rand_0, p_rand_0});
  endtask

  task automatic test_reset();
    reset_0 = 1'b1;
    drive(1'b1, 8'h5A, 8'h11, 8'h22, 1'b1, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (rand_ack !== 1'b0) begin errors++; $display("FAIL reset_rand_ack got=%b exp=0", rand_ack); end
    @(posedge clock_0);
    @(negedge clock_0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_shares !== 16'h0) begin errors++; $display("FAIL reset_out_shares got=%h exp=0000", out_shares); end
    reset_0 = 1'b0;
    exp_q.delete();
  endtask

`ifndef SHARE_ENC_REFRESH_EN
  task automatic test_basic();
    logic acc;
    drive(1'b1, 8'hA5, 8'h3C, 8'h00, 1'b1, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
    checks++; if (rand_ack !== 1'b1) begin errors++; $display("FAIL basic_rand_ack got=%b exp=1", rand_ack); end
    model_edge(acc);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_shares !== 16'h993C) begin errors++; $display("FAIL basic_shares got=%h exp=993c", out_shares); end
    checks++; if (rand_ack !== 1'b0) begin errors++; $display("FAIL basic_idle_ack got=%b exp=0", rand_ack); end
    model_edge(acc);
  endtask

  task automatic test_stall();
    logic acc;
    logic [15:0] held;
    drive(1'b1, 8'hC3, 8'h5E, 8'h00, 1'b1, 1'b1);
    model_edge(acc);
    held = {8'hC3 ^ 8'h5E, 8'h5E};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 8'h00, 1'b1, 1'b0);
      checks++; if (out_valid !== 1'b1 || out_shares !== held)
        begin errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", i, out_valid, out_shares, held); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
      checks++; if (rand_ack !== 1'b0) begin errors++; $display("FAIL stall_rand_ack cyc=%0d got=%b exp=0", i, rand_ack); end
      model_edge(acc);
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    model_edge(acc);
  endtask

  task automatic test_streaming();
    logic acc;
    int n_out = 0;
    for (int i = 0; i < 18; i++) begin
      drive(i < 16, 8'(i), 8'($urandom), 8'h00, 1'b1, 1'b1);
      if (i >= 1 && i <= 16) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=1", i, out_valid); end
      end
      if (out_valid) begin
        checks++; if ((out_shares[7:0] ^ out_shares[15:8]) !== 8'(n_out))
          begin errors++; $display("FAIL stream_recombine got=%h exp=%h", out_shares[7:0] ^ out_shares[15:8], 8'(n_out)); end
        if (exp_q.size() > 0) begin
          checks++; if (out_shares !== exp_q[0]) begin errors++; $display("FAIL stream_shares got=%h exp=%h", out_shares, exp_q[0]); end
        end
        n_out++;
      end
      model_edge(acc);
    end
    checks++; if (n_out != 16) begin errors++; $display("FAIL stream_count got=%0d exp=16", n_out); end
  endtask

  task automatic test_starvation();
    logic acc;
    logic [7:0] prng;
    bit seen[256];
    prng = 8'($urandom);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'($urandom), prng, 8'h00, (i % 2) == 0, 1'b1);
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL starve_in_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_ready()); end
      checks++; if (rand_ack !== exp_ready()) begin errors++; $display("FAIL starve_rand_ack cyc=%0d got=%b exp=%b", i, rand_ack, exp_ready()); end
      checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL starve_out_valid cyc=%0d got=%b", i, out_valid); end
      if (out_valid) begin
        checks++; if (seen[out_shares[7:0]]) begin errors++; $display("FAIL starve_dup_rand got=%h exp=fresh", out_shares[7:0]); end
        seen[out_shares[7:0]] = 1'b1;
      end
      model_edge(acc);
      if (acc) prng++;
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    model_edge(acc);
  endtask

  task automatic test_midflight_reset();
    logic acc;
    drive(1'b1, 8'h77, 8'hE1, 8'h00, 1'b1, 1'b0);
    model_edge(acc);
    @(negedge clock_0);
    reset_0 = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    checks++; if (rand_ack !== 1'b0) begin errors++; $display("FAIL midrst_rand_ack got=%b exp=0", rand_ack); end
    @(posedge clock_0);
    exp_q.delete();
    @(negedge clock_0);
    reset_0 = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_shares !== 16'h0) begin errors++; $display("FAIL midrst_shares got=%h exp=0000", out_shares); end
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 8'(8'h40 + i), 8'($urandom), 8'h00, 1'b1, 1'b1);
      checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL postrst_valid cyc=%0d got=%b", i, out_valid); end
      if (exp_q.size() > 0) begin
        checks++; if (out_shares !== exp_q[0]) begin errors++; $display("FAIL postrst_shares got=%h exp=%h", out_shares, exp_q[0]); end
      end
      model_edge(acc);
    end
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_ready()); end
      checks++; if (rand_ack !== (in_valid && exp_ready())) begin errors++; $display("FAIL rand_ack cyc=%0d got=%b", i, rand_ack); end
      checks++; if (out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rand_out_valid cyc=%0d got=%b", i, out_valid); end
      if (exp_q.size() > 0) begin
        checks++; if (out_shares !== exp_q[0]) begin errors++; $display("FAIL rand_shares cyc=%0d got=%h exp=%h", i, out_shares, exp_q[0]); end
      end
      model_edge(acc);
    end
  endtask
`else
  task automatic test_refresh();
    drive(1'b1, 8'hA5, 8'h3C, 8'h00, 1'b1, 1'b1);
    checks++; if (rand_ack !== 1'b1) begin errors++; $display("FAIL refresh_accept_ack got=%b exp=1", rand_ack); end
    @(posedge clock_0);
    drive(1'b0, 8'h00, 8'h00, 8'h0F, 1'b1, 1'b1);
    checks++; if (rand_ack !== 1'b1) begin errors++; $display("FAIL refresh_load_ack got=%b exp=1", rand_ack); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL refresh_early_valid got=%b exp=0", out_valid); end
    @(posedge clock_0);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL refresh_valid got=%b exp=1", out_valid); end
    checks++; if (out_shares !== 16'h9633) begin errors++; $display("FAIL refresh_shares got=%h exp=9633", out_shares); end
    checks++; if ((out_shares[7:0] ^ out_shares[15:8]) !== 8'hA5)
      begin errors++; $display("FAIL refresh_recombine got=%h exp=a5", out_shares[7:0] ^ out_shares[15:8]); end
    @(posedge clock_0);
  endtask
`endif

  initial begin
    test_reset();
`ifndef SHARE_ENC_REFRESH_EN
    test_basic();
    test_stall();
    test_streaming();
    test_starvation();
    test_midflight_reset();
    test_random();
`else
    test_refresh();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout exceeded 200000 time units");
    $fatal(1);
  end

endmodule
